bcd_updown_counter: RTL
=======================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with synchronous parallel load, terminal-count output for cascading, and wrap/error status pulses. It is the next-generation decimal counter for display, timer and event-count paths: it counts the full 0–9 range per digit across NUM_DIGITS digits and adds direction control and load.

## Interface

Parameters:
- NUM_DIGITS, 4: number of BCD digits, 1–8; digit 0 is least significant.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction; 1 = increment, 0 = decrement. Sampled only when a step occurs.
- load  in  1  synchronous parallel load request.
- load_val  in  4*NUM_DIGITS  value to load; digit i is bits [4i+3:4i].
- q  out  4*NUM_DIGITS  registered count; same digit packing as load_val.
- tc  out  1  combinational terminal count: en & (up ? all digits 9 : all digits 0).
- wrap  out  1  registered one-cycle pulse after a step that wrapped the count.
- load_err  out  1  registered one-cycle pulse after a rejected load.

## Operation

- Priority on each rising clk edge: rst_n low > load > en > hold.
- Reset (rst_n = 0): q = 0, wrap = 0, load_err = 0.
- Load (load = 1):
  - If every digit of load_val is ≤ 9, q ← load_val and load_err ← 0.
  - If any digit of load_val is ≥ 10 (A–F), q holds and load_err ← 1.
  - en is ignored in a load cycle, and wrap ← 0.
- Count up (en = 1, load = 0, up = 1):
  - Digit 0 increments.
  - A digit at 9 with carry-in goes to 0 and propagates carry to the next digit.
  - A digit below 9 with carry-in increments and stops the propagation.
- Count down (en = 1, load = 0, up = 0):
  - Digit 0 decrements.
  - A digit at 0 with borrow-in goes to 9 and propagates borrow.
- Wrap:
  - Up from all-9s gives all-0s; down from all-0s gives all-9s.
  - wrap ← 1 on that edge only.
- Hold (en = 0, load = 0): q holds, wrap ← 0, load_err ← 0.
- wrap and load_err are each 1 for exactly one cycle per event. They are 0 on every edge not producing their event.
- Digit arithmetic is 4-bit per digit, with carry and borrow rippling combinationally within a cycle. No binary addition is done across the full vector.
- q never holds a non-BCD digit. The only ways to reach q are reset, a validated load, or a count step.
- up may change every cycle; each step uses the current up.

## Timing

- Latency from en/load sampled high to new q: 1 cycle, on the same rising edge.
- tc is valid in the same cycle as q/en/up with no register. An upper cascade stage uses tc as its en.
- wrap is asserted in the cycle following the edge that wrapped q, i.e. alongside the new q value.
- load_err is asserted in the cycle following the rejected load.
- rst_n low mid-count or during load: q = 0 on that edge. No pulse is emitted and a pending load is discarded.
- Back-to-back loads are each evaluated independently, one per cycle.

## Configuration

- Macro: BCD_SATURATE_EN.
- Undefined (default): wrap-around as in Operation.
- Defined: saturating mode.
  - Up at all-9s, or down at all-0s, leaves q unchanged.
  - wrap is tied to 0.
  - tc still reports the terminal condition.
  - Load and reset behaviour are unchanged.

## Structure

- Package bcd_pkg holds:
  - BCD_MAX = 4'd9 and BCD_MIN = 4'd0.
  - The 4-bit digit typedef.
  - A function that checks a digit is valid BCD.
- Sub-module bcd_digit holds one digit register, generated NUM_DIGITS times.
  - Inputs: clk, rst_n, load, load_digit, step, up, cin.
  - Outputs: digit and cout, where cout = cin & (up ? digit==9 : digit==0).
- The top level contains:
  - the generate loop and carry/borrow chain;
  - the load validity reduction;
  - the tc, wrap and load_err logic;
  - the saturation gate under BCD_SATURATE_EN.

## Test plan

- Reset, then en = 1 and up = 1 for 10 cycles with NUM_DIGITS = 2 → q steps 00…09, then 10. Digit 0 reaches 9 before rolling over, and wrap stays 0.
- Load 9999, then one up step with NUM_DIGITS = 4 → q = 0000, wrap = 1 for one cycle. tc = 1 in the cycle before the step.
- Load 0100, then down one step → q = 0099. Load 0000, then down one step → q = 9999 and wrap = 1.
- Load 12A4 → q unchanged and load_err = 1 for one cycle. Load 1234 with en = 1 in the same cycle → q = 1234 and no count step.
- rst_n = 0 asserted in the same cycle as load = 1 and en = 1 → q = 0000, wrap = 0, load_err = 0.
- BCD_SATURATE_EN defined: load 9999 and count up 3 cycles → q stays 9999, wrap never asserts, tc = 1 throughout.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD up/down counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // A nibble is valid BCD when it does not exceed 9 (A-F are illegal).
  function automatic logic bcd_is_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with load and carry/borrow-qualified step.
// Latency: 1 cycle from load/step to new digit value.
// Backpressure: none; steps whenever step & cin on a clock edge.
//
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   load        - load load_digit (already validated by the parent)
//   load_digit  - value to load
//   step        - a count step is happening this cycle
//   up          - direction, 1 = increment
//   cin         - carry (up) or borrow (down) from the lower digit
//   digit       - registered digit value
//   cout        - cin & (up ? digit==9 : digit==0), feeds the next digit
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  logic at_limit;

  // The limit depends on direction: 9 rolls over going up, 0 going down.
  assign at_limit = up ? (digit == BCD_MAX) : (digit == BCD_MIN);
  assign cout     = cin & at_limit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= load_digit;
    end else if (step && cin) begin
      if (up) begin
        digit <= at_limit ? BCD_MIN : bcd_digit_t'(digit + 4'd1);
      end else begin
        digit <= at_limit ? BCD_MAX : bcd_digit_t'(digit - 4'd1);
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with validated parallel load, tc, wrap and load_err.
// Latency: 1 cycle from en/load to q; tc is combinational; wrap/load_err are 1-cycle pulses after the event.
// Backpressure: none; counts one step per cycle while en is high, load has priority over en.
//
// Ports:
//   clk, rst_n - clock and synchronous active-low reset
//   en, up     - count enable and direction (1 = increment)
//   load       - parallel load request, load_val digit i at [4i+3:4i]
//   q          - registered count, same packing as load_val
//   tc         - en & (all digits at the terminal value for the current direction)
//   wrap       - pulse after a step that wrapped the whole count
//   load_err   - pulse after a load rejected for containing a non-BCD digit
//
// Build option: define BCD_SATURATE_EN to stop at 9..9 / 0..0 instead of
// wrapping; wrap is then held at 0 while tc still reports the terminal state.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] q,
  output logic                    tc,
  output logic                    wrap,
  output logic                    load_err
);

  logic [NUM_DIGITS-1:0] digit_ok;
  logic                  load_ok;
  logic                  load_take;
  logic                  at_term;
  logic                  step;
  logic                  wrap_nxt;

  // Each digit lives in its own generate scope so the ripple chain is a
  // series of separate nets rather than one self-referencing vector.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_dig
    logic cin_w;
    logic cout_w;

    if (g == 0) begin : gen_lsd
      // The least significant digit always moves on a step.
      assign cin_w = 1'b1;
    end else begin : gen_chain
      assign cin_w = gen_dig[g-1].cout_w;
    end

    assign digit_ok[g] = bcd_is_valid(load_val[4*g +: 4]);

    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_take),
      .load_digit (load_val[4*g +: 4]),
      .step       (step),
      .up         (up),
      .cin        (cin_w),
      .digit      (q[4*g +: 4]),
      .cout       (cout_w)
    );
  end

  // A single illegal nibble rejects the whole load; q then holds.
  assign load_ok   = &digit_ok;
  assign load_take = load & load_ok;

  // Carry out of the top digit means every digit sits at the terminal value.
  assign at_term = gen_dig[NUM_DIGITS-1].cout_w;
  assign tc      = en & at_term;

`ifdef BCD_SATURATE_EN
  assign step     = en & ~load & ~at_term;
  assign wrap_nxt = 1'b0;
`else
  assign step     = en & ~load;
  assign wrap_nxt = en & ~load & at_term;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= wrap_nxt;
      load_err <= load & ~load_ok;
    end
  end

endmodule
